register_renew_dispatcher: RTL
==============================

# register_renew_dispatcher

Issue side of the register-renew handshake. Accepts decoded work requests (one or three destination registers plus a source-register mask), stalls on register hazards and selects a free core. It then pulses the boot-renew strobes and `register_num` into the register-management block, and tracks each core until that block retires the renew. It also serves barrier requests that wait for both cores to be in sync.

## Interface
- `REGISTER_AMOUNT`, 32, architectural register count
- `REG_CTN_WIDTH`, `$clog2(REGISTER_AMOUNT)`, register index width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  `state==IDLE`, combinational
- `req_triple`  in  1  three-destination request, core 2 only
- `req_sync`  in  1  barrier request; other request fields ignored
- `req_dest`  in  `REG_CTN_WIDTH*3`  destination fields; field k = bits `[5k+4:5k]`
- `req_src_mask`  in  `REGISTER_AMOUNT`  registers read by the request
- `processor_idle_1`, `processor_idle_2`  in  1 each  core idle flags
- `processing_register_table`  in  `REGISTER_AMOUNT`  in-flight registers reported by register management
- `synchronized_processors`  in  1  both cores synchronized
- `boot_renew_register_1`, `boot_renew_register_2`  out  1 each  single-register renew pulse
- `boot_renew_3registers_1`  out  1  constant 0 (no core-1 triple path)
- `boot_renew_3registers_2`  out  1  triple renew pulse
- `register_num`  out  `REG_CTN_WIDTH*3`  registered; valid during a pulse
- `sync_done`  out  1  one-cycle barrier completion pulse
- `busy`  out  1  state≠IDLE or any tracker ≠ FREE

## Operation
- States: IDLE, CHECK, SYNC_WAIT.
- IDLE:
  - On `req_valid`, latch all request fields and go to CHECK.
- Destination mask `dmask`:
  - Decode of field 0. When `req_triple=1`, also fields 1 and 2.
  - Bits 0 and 1 are always cleared.
- `local_mask_x`: dest mask of the op in flight on core x. Set on issue; cleared when tracker x returns to FREE.
- Hazard = `|((processing_register_table | local_mask_1 | local_mask_2) & (dmask | req_src_mask))`.
- CHECK:
  - A hazard holds CHECK.
  - Core x is eligible when tracker x is FREE and `processor_idle_x=1`.
  - A triple request needs core 2 eligible.
  - A single request takes core 1 if eligible, else core 2, else holds.
  - On issue, the boot pulse is registered high for exactly one cycle and the state returns to IDLE.
  - `register_num` is driven as follows:
    - Single: field 0 in the low bits, upper fields 0.
    - Triple: all three fields.
- Single request with field 0 ∈ {0,1}: retired from CHECK to IDLE with no pulse.
- Per-core tracker x: FREE → ARMED on issue; ARMED → RUNNING when `processor_idle_x=0`; RUNNING → FREE when `processor_idle_x=1`.
- SYNC_WAIT (entered from CHECK when `req_sync=1`):
  - Waits until both trackers are FREE and `synchronized_processors=1`.
  - Then pulses `sync_done` for 1 cycle and returns to IDLE.

## Timing
- Reset values: state IDLE (`req_ready=1` during and after reset), trackers FREE, masks 0, all boot strobes 0, `register_num=0`, `sync_done=0`, `busy=0`.
- A request accepted at edge T is evaluated in cycle T+1. With no hazard, the boot pulse is high in cycle T+2 and `req_ready=1` again in T+2.
- Throughput: at most one issue per 2 cycles.
- Pulse width is exactly 1 cycle, never back-to-back on the same core.
- `local_mask` covers the one-cycle lag before `processing_register_table` reflects the issue.
- A core whose idle flag never drops stays ARMED indefinitely; no timeout.
- `rst` mid-operation drops any pulse in progress and clears trackers; the latched request is discarded.

## Configuration
- `DISPATCH_STALL_CNT_EN` defined:
  - Adds output `stall_count` [15:0], reset 0.
  - Increments once per cycle spent in CHECK without issue, and per cycle in SYNC_WAIT.
  - Saturates at 16'hFFFF.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

## Test plan
- Single request, dest 5, both cores idle, table 0 → `boot_renew_register_1` high in T+2, `register_num=5`; core 2 strobes stay 0.
- Tracker 1 ARMED, new single request dest 7 → issues on core 2 with `register_num=7`.
- Triple request dests 3/4/6 while `processing_register_table[4]=1` → holds in CHECK. After bit 4 clears: `boot_renew_3registers_2` pulse, `register_num={6,4,3}`.
- Request with `req_src_mask` bit 5 set immediately after issuing dest 5 (table not yet set) → stalls on `local_mask_1` until tracker 1 is FREE.
- Sync request with tracker 2 RUNNING and `synchronized_processors=0` → no `sync_done`. Tracker FREE and sync=1 → one-cycle `sync_done`.
- Assert `rst` during the pulse cycle → strobes 0 immediately, `busy=0`, `req_ready=1`; with `DISPATCH_STALL_CNT_EN`, `stall_count=0`.

Source files
------------

// File: rtl/register_renew_dispatcher_if.sv
// Request bus into the register-renew dispatcher: decoded work or barrier request with valid/ready.
interface register_renew_dispatcher_if #(
  parameter int REGISTER_AMOUNT = 32,
  parameter int REG_CTN_WIDTH   = $clog2(REGISTER_AMOUNT)
);
  logic                         req_valid;
  logic                         req_ready;
  logic                         req_triple;
  logic                         req_sync;
  logic [REG_CTN_WIDTH*3-1:0]   req_dest;
  logic [REGISTER_AMOUNT-1:0]   req_src_mask;

  modport master (
    output req_valid, req_triple, req_sync, req_dest, req_src_mask,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_triple, req_sync, req_dest, req_src_mask,
    output req_ready
  );
endinterface

// File: rtl/register_renew_dispatcher.sv
// Issues boot-renew pulses to a free core once register hazards clear, tracks each core, serves barriers.
// Optional stall counter output enabled by defining DISPATCH_STALL_CNT_EN.
module register_renew_dispatcher #(
  parameter int REGISTER_AMOUNT = 32,
  parameter int REG_CTN_WIDTH   = $clog2(REGISTER_AMOUNT)
) (
  input  logic                        clk,
  input  logic                        rst,
  register_renew_dispatcher_if.slave  req_bus,
  input  logic                        processor_idle_1,
  input  logic                        processor_idle_2,
  input  logic [REGISTER_AMOUNT-1:0]  processing_register_table,
  input  logic                        synchronized_processors,
  output logic                        boot_renew_register_1,
  output logic                        boot_renew_register_2,
  output logic                        boot_renew_3registers_1,
  output logic                        boot_renew_3registers_2,
  output logic [REG_CTN_WIDTH*3-1:0]  register_num,
  output logic                        sync_done,
`ifdef DISPATCH_STALL_CNT_EN
  output logic [15:0]                 stall_count,
`endif
  output logic                        busy
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] CHECK     = 2'd1;
  localparam logic [1:0] SYNC_WAIT = 2'd2;

  localparam logic [1:0] T_FREE    = 2'd0;
  localparam logic [1:0] T_ARMED   = 2'd1;
  localparam logic [1:0] T_RUNNING = 2'd2;

  logic [1:0]                 state;
  logic                       lat_triple;
  logic                       lat_sync;
  logic [REG_CTN_WIDTH*3-1:0] lat_dest;
  logic [REGISTER_AMOUNT-1:0] lat_src;

  logic [1:0]                 trk_1, trk_2;
  logic [REGISTER_AMOUNT-1:0] local_mask_1, local_mask_2;

  logic [REGISTER_AMOUNT-1:0] dmask;
  logic hazard, elig_1, elig_2, trivial, evaluating;
  logic issue_1, issue_2, retire, sync_fire;

  always_comb begin
    dmask = '0;
    dmask[lat_dest[REG_CTN_WIDTH-1:0]] = 1'b1;
    if (lat_triple) begin
      dmask[lat_dest[2*REG_CTN_WIDTH-1:REG_CTN_WIDTH]]   = 1'b1;
      dmask[lat_dest[3*REG_CTN_WIDTH-1:2*REG_CTN_WIDTH]] = 1'b1;
    end
    dmask[1:0] = 2'b00;
  end

  // local masks close the gap until the register table shows the freshly issued renew
  assign hazard  = |((processing_register_table | local_mask_1 | local_mask_2) & (dmask | lat_src));
  assign elig_1  = (trk_1 == T_FREE) && processor_idle_1;
  assign elig_2  = (trk_2 == T_FREE) && processor_idle_2;
  assign trivial = !lat_triple && (lat_dest[REG_CTN_WIDTH-1:1] == '0);

  assign evaluating = (state == CHECK) && !lat_sync;
  assign retire     = evaluating && trivial;
  assign issue_1    = evaluating && !trivial && !hazard && !lat_triple && elig_1;
  assign issue_2    = evaluating && !trivial && !hazard &&
                      (lat_triple ? elig_2 : (!elig_1 && elig_2));
  assign sync_fire  = (state == SYNC_WAIT) && (trk_1 == T_FREE) && (trk_2 == T_FREE) &&
                      synchronized_processors;

  assign req_bus.req_ready       = (state == IDLE);
  assign boot_renew_3registers_1 = 1'b0;
  assign busy = (state != IDLE) || (trk_1 != T_FREE) || (trk_2 != T_FREE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lat_triple <= 1'b0;
      lat_sync   <= 1'b0;
      lat_dest   <= '0;
      lat_src    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_bus.req_valid) begin
            lat_triple <= req_bus.req_triple;
            lat_sync   <= req_bus.req_sync;
            lat_dest   <= req_bus.req_dest;
            lat_src    <= req_bus.req_src_mask;
            state      <= CHECK;
          end
        end
        CHECK: begin
          if (lat_sync)                        state <= SYNC_WAIT;
          else if (retire || issue_1 || issue_2) state <= IDLE;
        end
        SYNC_WAIT: begin
          if (sync_fire) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      boot_renew_register_1   <= 1'b0;
      boot_renew_register_2   <= 1'b0;
      boot_renew_3registers_2 <= 1'b0;
      sync_done               <= 1'b0;
      register_num            <= '0;
    end else begin
      boot_renew_register_1   <= issue_1;
      boot_renew_register_2   <= issue_2 && !lat_triple;
      boot_renew_3registers_2 <= issue_2 && lat_triple;
      sync_done               <= sync_fire;
      if (issue_1 || issue_2)
        register_num <= lat_triple ? lat_dest
                                   : (REG_CTN_WIDTH*3)'(lat_dest[REG_CTN_WIDTH-1:0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk_1        <= T_FREE;
      local_mask_1 <= '0;
    end else begin
      case (trk_1)
        T_FREE:    if (issue_1) begin trk_1 <= T_ARMED; local_mask_1 <= dmask; end
        T_ARMED:   if (!processor_idle_1) trk_1 <= T_RUNNING;
        T_RUNNING: if (processor_idle_1) begin trk_1 <= T_FREE; local_mask_1 <= '0; end
        default:   begin trk_1 <= T_FREE; local_mask_1 <= '0; end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk_2        <= T_FREE;
      local_mask_2 <= '0;
    end else begin
      case (trk_2)
        T_FREE:    if (issue_2) begin trk_2 <= T_ARMED; local_mask_2 <= dmask; end
        T_ARMED:   if (!processor_idle_2) trk_2 <= T_RUNNING;
        T_RUNNING: if (processor_idle_2) begin trk_2 <= T_FREE; local_mask_2 <= '0; end
        default:   begin trk_2 <= T_FREE; local_mask_2 <= '0; end
      endcase
    end
  end

`ifdef DISPATCH_STALL_CNT_EN
  logic stall_cycle;
  assign stall_cycle = ((state == CHECK) && !issue_1 && !issue_2) || (state == SYNC_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      stall_count <= 16'h0000;
    else if (stall_cycle && stall_count != 16'hFFFF) stall_count <= stall_count + 16'h0001;
  end
`endif

endmodule
